uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and baud divisor helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    // Clock cycles per line bit; shared with the matching receiver.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick is high on the last cycle of each bit.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          tick_q;

    always_comb begin
        cnt_nxt = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_nxt = '0;
        end
    end

    // tick is registered from the next count so it lines up with cnt == LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            tick_q <= (cnt_nxt == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 framing.
// tx and txBusy are driven straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              txStart,
    input  logic [DATA_W-1:0] txData,
    output logic              txBusy,
    output logic              tx
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] shreg_q, shreg_nxt;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_nxt;
    logic              tx_q, tx_nxt;
    logic              busy_q, busy_nxt;
    logic              bit_clear;
    logic              bit_tick;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_nxt;
`endif

    // Counter is held at 0 while idle so START always gets a full bit period.
    assign bit_clear = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(bit_clear),
        .tick (bit_tick)
    );

    always_comb begin
        state_nxt   = state_q;
        shreg_nxt   = shreg_q;
        bit_idx_nxt = bit_idx_q;
        tx_nxt      = tx_q;
        busy_nxt    = busy_q;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (txStart) begin
                    state_nxt   = ST_START;
                    shreg_nxt   = txData;
                    bit_idx_nxt = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_nxt     = ^txData;
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_nxt = ST_DATA;
                    tx_nxt    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    bit_idx_nxt = bit_idx_q + IDX_W'(1);
                    shreg_nxt   = {1'b0, shreg_q[DATA_W-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        tx_nxt = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_nxt = 1'b1;
                if (bit_tick) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            shreg_q   <= shreg_nxt;
            bit_idx_q <= bit_idx_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= busy_nxt;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_nxt;
`endif
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLK_HZ=8, BAUD=2 (4 clocks per bit).
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk;
    logic       rst_n;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic       tx;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CLK_HZ(8),
        .BAUD  (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .txStart(txStart),
        .txData (txData),
        .txBusy (txBusy),
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference line level c cycles after the accepting edge for byte b.
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int         bitn;
        logic [7:0] t;
        bitn = c / CPB;
        if (c >= FRAME) return 1'b1;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) begin
            t = b >> (bitn - 1);
            return t[0];
        end
`ifdef UART_TX_PARITY_EN
        if (bitn == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // mode 0: plain; 1: pulse txStart with 0x3C mid-DATA; 2: scramble txData every cycle.
    task automatic run_frame(input logic [7:0] d, input int mode, input logic [7:0] exp_byte,
                             input logic exp_par, input string nm);
        logic act_tx [0:FRAME];
        logic act_busy [0:FRAME];
        logic [7:0] dec;
        int   first_bad;
        int   busy_cnt;
        txData  = d;
        txStart = 1'b1;
        @(posedge clk); #1;
        txStart = 1'b0;
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            act_tx[c]   = tx;
            act_busy[c] = txBusy;
            @(posedge clk); #1;
            if (mode == 1 && c == 19) begin
                txStart = 1'b1;
                txData  = 8'h3C;
            end else if (mode == 1 && c == 20) begin
                txStart = 1'b0;
            end else if (mode == 2) begin
                txData = 8'($urandom);
            end
        end
        txStart = 1'b0;
        first_bad = -1;
        busy_cnt  = 0;
        for (int c = 0; c <= FRAME; c++) begin
            if (first_bad < 0 && act_tx[c] != exp_tx(exp_byte, c)) first_bad = c;
            if (act_busy[c]) busy_cnt++;
        end
        check({nm, "_wave_first_bad_cycle"}, first_bad, -1);
        check({nm, "_busy_cycles"}, busy_cnt, FRAME);
        check({nm, "_busy_end"}, int'(act_busy[FRAME]), 0);
        check({nm, "_start_bit"}, int'(act_tx[CPB / 2]), 0);
        for (int j = 0; j < 8; j++) dec[j] = act_tx[(1 + j) * CPB + CPB / 2];
        check({nm, "_byte"}, int'(dec), int'(exp_byte));
`ifdef UART_TX_PARITY_EN
        check({nm, "_parity"}, int'(act_tx[9 * CPB + CPB / 2]), int'(exp_par));
`else
        if (exp_par !== 1'bx) begin end
`endif
        check({nm, "_stop_bit"}, int'(act_tx[(FRAME_BITS - 1) * CPB + CPB / 2]), 1);
    endtask

    initial begin
        vec_t       vecs [5];
        logic       s_tx [0:2*FRAME];
        logic       s_busy [0:2*FRAME];
        int         n;
        int         first_bad;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 0, 8'h01, 1'b1};
        vecs[2] = '{8'h00, 0, 8'h00, 1'b0};
        vecs[3] = '{8'h81, 1, 8'h81, 1'b0};
        vecs[4] = '{8'hF0, 2, 8'hF0, 1'b0};

        // Reset with a start request present: must stay idle.
        rst_n   = 1'b0;
        txStart = 1'b1;
        txData  = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(txBusy), 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        txStart = 1'b0;
        @(negedge clk);
        check("post_reset_tx", int'(tx), 1);
        check("post_reset_busy", int'(txBusy), 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].mode, vecs[i].exp_byte, vecs[i].exp_par,
                      $sformatf("vec%0d", i));
            repeat (i % 3) begin
                @(posedge clk); #1;
            end
        end

        // txStart held high: frames separated by exactly one idle cycle.
        txData  = 8'h55;
        txStart = 1'b1;
        n = 0;
        @(negedge clk);
        while (!txBusy && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("b2b_became_busy", int'(txBusy), 1);
        for (int c = 0; c <= 2 * FRAME; c++) begin
            s_tx[c]   = tx;
            s_busy[c] = txBusy;
            @(negedge clk);
        end
        first_bad = -1;
        for (int c = 0; c <= 2 * FRAME; c++) begin
            logic etx, ebusy;
            if (c < FRAME) begin
                etx = exp_tx(8'h55, c); ebusy = 1'b1;
            end else if (c == FRAME) begin
                etx = 1'b1; ebusy = 1'b0;
            end else begin
                etx = exp_tx(8'h55, c - FRAME - 1); ebusy = 1'b1;
            end
            if (first_bad < 0 && (s_tx[c] != etx || s_busy[c] != ebusy)) first_bad = c;
        end
        check("b2b_first_bad_cycle", first_bad, -1);
        @(posedge clk); #1;
        txStart = 1'b0;
        repeat (2 * FRAME) @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_drain_busy", int'(txBusy), 0);
        check("b2b_drain_tx", int'(tx), 1);
        @(posedge clk); #1;

        // Reset during data bit 3 aborts the frame on that edge.
        txData  = 8'hC3;
        txStart = 1'b1;
        @(posedge clk); #1;
        txStart = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 17) check("rst_pre_tx_d3", int'(tx), 0);
            @(posedge clk); #1;
        end
        rst_n   = 1'b0;
        txStart = 1'b1;
        txData  = 8'hFF;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        txStart = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_busy", int'(txBusy), 0);
        @(negedge clk);
        check("rst_start_ignored_busy", int'(txBusy), 0);
        @(posedge clk); #1;
        run_frame(8'h96, 0, 8'h96, 1'b0, "after_rst");

        // Random bytes against the reference model.
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            run_frame(d, 0, d, ^d, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
